// File: rtl/sram_mem_arbiter.sv
// Arbitrates the IF and data ports onto one single-port 16-bit SRAM. Each 32-bit word access
// runs as a LO then a HI phase. The FAIR_ARB_EN macro selects round-robin arbitration on simultaneous requests.
module sram_mem_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              busy,
    output logic [ADDR_W:0]   sram_addr,
    input  logic [15:0]       sram_dq_in,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_we_n,
    output logic              sram_oe_n
);
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] LAST_CNT   = 4'(WAIT_CYCLES);
    localparam logic [3:0] WE_END_CNT = 4'(WAIT_CYCLES - 1);

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [31:0]       wdata_r;
    logic              own_d_r;
    logic [15:0]       lo_buf_r;

    logic              grant_d_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              phase_end_s;
    logic              we_end_s;
`ifdef FAIR_ARB_EN
    logic              last_d_r;
`endif

    // Owner selection for the IDLE grant; a tie goes to data unless round-robin is enabled
    always_comb begin
        grant_d_s = 1'b0;
`ifdef FAIR_ARB_EN
        if (d_req && if_req) begin
            grant_d_s = ~last_d_r;
        end else begin
            grant_d_s = d_req;
        end
`else
        grant_d_s = d_req;
`endif
        sel_we_s   = grant_d_s & d_we;
        sel_addr_s = if_addr;
        if (grant_d_s) begin
            sel_addr_s = d_addr;
        end else begin
            sel_addr_s = if_addr;
        end
    end

    // Phase timing decodes; we_n rises one cycle before the phase ends
    always_comb begin
        phase_end_s = (cnt_r == LAST_CNT);
        we_end_s    = (cnt_r == WE_END_CNT);
    end

    // Access sequencer with all SRAM and port outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= '0;
            we_r        <= 1'b0;
            wdata_r     <= 32'd0;
            own_d_r     <= 1'b0;
            lo_buf_r    <= 16'd0;
            if_rdata    <= 32'd0;
            if_ready    <= 1'b0;
            d_rdata     <= 32'd0;
            d_ready     <= 1'b0;
            busy        <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= 16'd0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
`ifdef FAIR_ARB_EN
            last_d_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (d_req || if_req) begin
                        state_r    <= LO;
                        cnt_r      <= 4'd0;
                        own_d_r    <= grant_d_s;
                        addr_r     <= sel_addr_s;
                        we_r       <= sel_we_s;
                        wdata_r    <= d_wdata;
                        sram_addr  <= {sel_addr_s, 1'b0};
                        sram_dq_oe <= sel_we_s;
                        sram_we_n  <= ~sel_we_s;
                        sram_oe_n  <= sel_we_s;
                        busy       <= 1'b1;
                        if (sel_we_s) begin
                            sram_dq_out <= d_wdata[15:0];
                        end
`ifdef FAIR_ARB_EN
                        last_d_r   <= grant_d_s;
`endif
                    end
                end
                LO: begin
                    if (phase_end_s) begin
                        state_r   <= HI;
                        cnt_r     <= 4'd0;
                        lo_buf_r  <= sram_dq_in;
                        sram_addr <= {addr_r, 1'b1};
                        sram_we_n <= ~we_r;
                        if (we_r) begin
                            sram_dq_out <= wdata_r[31:16];
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                        if (we_end_s) begin
                            sram_we_n <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (phase_end_s) begin
                        state_r    <= DONE;
                        cnt_r      <= 4'd0;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (own_d_r) begin
                            d_ready <= 1'b1;
                            if (!we_r) begin
                                d_rdata <= {sram_dq_in, lo_buf_r};
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= {sram_dq_in, lo_buf_r};
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                        if (we_end_s) begin
                            sram_we_n <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r  <= IDLE;
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    cnt_r      <= 4'd0;
                    if_ready   <= 1'b0;
                    d_ready    <= 1'b0;
                    busy       <= 1'b0;
                    sram_we_n  <= 1'b1;
                    sram_oe_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/sram_mem_arbiter.md
# sram_mem_arbiter

Shares the board's single-port 16-bit external SRAM between the pipeline's instruction-fetch port and data-memory port. Each 32-bit word access becomes two sequenced 16-bit SRAM phases, low half first. The block sits between the IF/MEM stages and the SRAM pins. It returns a one-cycle ready pulse per port, which the pipeline uses to release its freeze.

## Interface
Parameters:
- WAIT_CYCLES, 1: extra cycles each 16-bit phase is held; legal range 1..15.
- ADDR_W, 17: word-address width; the SRAM address is ADDR_W+1 bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  instruction read request; held until if_ready.
- if_addr  in  ADDR_W  instruction word address.
- if_rdata  out  32  fetched word; valid in the if_ready cycle and held until the next IF completion.
- if_ready  out  1  one-cycle completion pulse for the IF port.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read word; valid in the d_ready cycle and held until the next data-read completion.
- d_ready  out  1  one-cycle completion pulse for the data port; pulses for writes and reads.
- busy  out  1  high whenever the FSM is not in IDLE.
- sram_addr  out  ADDR_W+1  {word address, half select}.
- sram_dq_in  in  16  SRAM read data.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_oe  out  1  drives the tristate enable at the top level.
- sram_we_n  out  1  active-low write strobe.
- sram_oe_n  out  1  active-low output enable.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If either request is high, pick an owner (see below) and latch addr, we, wdata and owner. Go to LO.
  - Otherwise stay in IDLE.
- Arbitration (default, fixed priority): if d_req and if_req are both high, the data port wins.
- LO and HI phases: each lasts WAIT_CYCLES+1 cycles, timed by a 4-bit phase counter that clears on phase entry.
  - sram_addr = {addr, 0} in LO and {addr, 1} in HI.
- Read phase:
  - sram_oe_n is low for the whole phase.
  - sram_dq_in is captured on the phase's last cycle: into [15:0] in LO, into [31:16] in HI.
- Write phase:
  - sram_dq_oe = 1 for the whole phase.
  - sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
  - sram_we_n is low on every cycle of the phase except the last, so address and data are stable at the we_n rising edge.
  - sram_oe_n stays high.
- DONE:
  - Pulse the owner's ready for exactly one cycle.
  - For reads, present the assembled word on the owner's rdata.
  - Return to IDLE.
  - The non-owner's outputs are unchanged.
- The requester drops or changes its request at the edge that ends its ready cycle. A req still high in the following IDLE cycle is treated as a new access.
- A request arriving during LO, HI or DONE waits; nothing is queued beyond the level-held req.
- Outside LO/HI: sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0, sram_addr holds its last value.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0.
  - if_ready = d_ready = busy = 0.
  - if_rdata = d_rdata = 0.
  - sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0.
  - sram_we_n = 1, sram_oe_n = 1.
  - last-owner flag = IF.
- All outputs are registered.
- Latency: a request sampled in IDLE at cycle 0 gets ready at cycle 2·WAIT_CYCLES+3; at the default WAIT_CYCLES=1, ready is at cycle 5.
- Back-to-back throughput: one word per 2·WAIT_CYCLES+4 cycles.
- busy rises the cycle after the grant and falls the cycle after DONE.
- Reset asserted mid-access: everything returns to reset values immediately and asynchronously.
  - The SRAM strobes deassert without waiting for the phase end.
  - The partial write is abandoned and no ready is issued.
- Address wrap: sram_addr is exactly {addr, half} with no carry; the top address behaves like any other.

## Configuration
- FAIR_ARB_EN defined:
  - Round-robin on simultaneous requests: the port that was not the last owner wins.
  - The last-owner flag updates at each grant.
  - The first tie after reset goes to data.
  - Guarantees IF is not starved by a continuous d_req.
- FAIR_ARB_EN undefined: fixed data-over-IF priority; the last-owner flag is not implemented.

## Test plan
- IF read at addr 0x00010, SRAM model returns 0x1234 at half address 0x20 and 0xABCD at 0x21 -> if_ready at cycle 5, if_rdata = 0xABCD1234, sram_oe_n low for cycles 1-4.
- Data write at d_addr 0x00003, d_wdata 0xCAFEF00D -> SRAM half 0x06 = 0xF00D, half 0x07 = 0xCAFE; sram_we_n low only in cycles 1 and 3; d_ready at cycle 5.
- if_req and d_req both high at cycle 0:
  - Without FAIR_ARB_EN: data is served first, then IF; if_ready at cycle 11.
  - With FAIR_ARB_EN and d_req held continuously: grants alternate D, IF, D.
- WAIT_CYCLES=3, data read -> each phase lasts 4 cycles; d_ready at cycle 9.
- rst driven low in cycle 2 of a write -> sram_we_n = 1 and sram_dq_oe = 0 within the same cycle; no d_ready; the next request starts from IDLE.
- d_req held high through its ready cycle -> a second identical access starts the cycle after DONE; busy deasserts for exactly one cycle between the two accesses.
